// File: rtl/md_sched_pkg.sv
// Shared encodings for the multiply/divide scheduler: operation codes, FSM states,
// and the MIPS opcode/funct values of the HI/LO instruction family.
package md_sched_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MTHI    = 6'h11;
  localparam logic [5:0] FN_MFLO    = 6'h12;
  localparam logic [5:0] FN_MTLO    = 6'h13;
  localparam logic [5:0] FN_MULT    = 6'h18;
  localparam logic [5:0] FN_MULTU   = 6'h19;
  localparam logic [5:0] FN_DIV     = 6'h1A;
  localparam logic [5:0] FN_DIVU    = 6'h1B;

  localparam logic [31:0] MD_INT_MIN = 32'h8000_0000;
  localparam logic [31:0] MD_NEG_ONE = 32'hFFFF_FFFF;

  // Divide-class ops take the long latency.
  function automatic logic md_is_div(input md_op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/md_sched_if.sv
// EX/ID-side bundle of the multiply/divide scheduler: issue, HI/LO writes,
// the ID hazard probe, and the status/result outputs.
interface md_sched_if;
  logic        start;
  logic [1:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        wr_hi;
  logic        wr_lo;
  logic [31:0] wr_data;
  logic        id_md_use;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, md_op, src_a, src_b, wr_hi, wr_lo, wr_data, id_md_use,
    input  busy, stall, done, hi, lo
  );

  modport slave (
    input  start, md_op, src_a, src_b, wr_hi, wr_lo, wr_data, id_md_use,
    output busy, stall, done, hi, lo
  );
endinterface

// File: rtl/md_sched_compute.sv
// Combinational HI/LO result generator for mult/multu/div/divu, including the
// divide-by-zero (keep HI/LO) and INT_MIN / -1 overflow rules.
module md_compute
  import md_sched_pkg::*;
(
  input  md_op_e      i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [31:0] i_cur_hi,
  input  logic [31:0] i_cur_lo,
  output logic [31:0] o_res_hi,
  output logic [31:0] o_res_lo
);

  logic signed [63:0] w_prod_s;
  logic        [63:0] w_prod_u;
  logic        [31:0] w_b_safe;
  logic signed [31:0] w_quot_s;
  logic signed [31:0] w_rem_s;
  logic        [31:0] w_quot_u;
  logic        [31:0] w_rem_u;
  logic               w_div_zero;
  logic               w_div_ovf;

  assign w_prod_s = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
  assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

  // A zero divisor is replaced so the dividers never see it; the result is discarded anyway.
  assign w_div_zero = (i_b == 32'd0);
  assign w_b_safe   = w_div_zero ? 32'd1 : i_b;
  assign w_div_ovf  = (i_a == MD_INT_MIN) && (i_b == MD_NEG_ONE);

  assign w_quot_s = $signed(i_a) / $signed(w_b_safe);
  assign w_rem_s  = $signed(i_a) % $signed(w_b_safe);
  assign w_quot_u = i_a / w_b_safe;
  assign w_rem_u  = i_a % w_b_safe;

  always_comb begin
    o_res_hi = i_cur_hi;
    o_res_lo = i_cur_lo;
    case (i_op)
      MD_MULT: begin
        o_res_hi = w_prod_s[63:32];
        o_res_lo = w_prod_s[31:0];
      end
      MD_MULTU: begin
        o_res_hi = w_prod_u[63:32];
        o_res_lo = w_prod_u[31:0];
      end
      MD_DIV: begin
        if (w_div_ovf) begin
          o_res_hi = 32'd0;
          o_res_lo = MD_INT_MIN;
        end else if (!w_div_zero) begin
          o_res_hi = w_rem_s;
          o_res_lo = w_quot_s;
        end
      end
      MD_DIVU: begin
        if (!w_div_zero) begin
          o_res_hi = w_rem_u;
          o_res_lo = w_quot_u;
        end
      end
      default: begin
        o_res_hi = i_cur_hi;
        o_res_lo = i_cur_lo;
      end
    endcase
  end

endmodule

// File: rtl/md_sched.sv
// Multi-cycle multiply/divide scheduler: fixed-latency busy window, HI/LO commit,
// mthi/mtlo writes and the ID stall request for md-class instructions.
module md_sched
  import md_sched_pkg::*;
#(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        rst,
  md_sched_if.slave   bus
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;
  localparam logic [CNT_W-1:0] MUL_CNT0 = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT0 = CNT_W'(DIV_LAT - 1);

  md_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_pend_hi;
  logic [31:0]      r_pend_lo;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic             r_busy;
  logic             r_done;

  md_op_e      w_op;
  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;

  assign w_op = md_op_e'(bus.md_op);

  md_compute u_compute (
    .i_op     (w_op),
    .i_a      (bus.src_a),
    .i_b      (bus.src_b),
    .i_cur_hi (r_hi),
    .i_cur_lo (r_lo),
    .o_res_hi (w_res_hi),
    .o_res_lo (w_res_lo)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= MD_IDLE;
      r_cnt     <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        MD_IDLE: begin
          // An issue takes priority over a same-cycle mthi/mtlo, which is dropped.
          if (bus.start) begin
            r_state   <= MD_RUN;
            r_busy    <= 1'b1;
            r_cnt     <= md_is_div(w_op) ? DIV_CNT0 : MUL_CNT0;
            r_pend_hi <= w_res_hi;
            r_pend_lo <= w_res_lo;
          end else begin
            if (bus.wr_hi) r_hi <= bus.wr_data;
            if (bus.wr_lo) r_lo <= bus.wr_data;
          end
        end
        MD_RUN: begin
          if (r_cnt == '0) begin
            r_state <= MD_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_hi    <= r_pend_hi;
            r_lo    <= r_pend_lo;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= MD_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.hi    = r_hi;
  assign bus.lo    = r_lo;
  assign bus.stall = bus.id_md_use & (r_busy | bus.start);

endmodule

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched: a cycle-level model built from the
// scheduling rules and 64-bit arithmetic, compared every cycle, plus literal pins.
module tb_md_sched;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  md_sched_if bus ();

  md_sched #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  int stall_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Result rule straight from the instruction semantics, using wide arithmetic.
  function automatic logic [63:0] ref_md(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] hi,
                                         input logic [31:0] lo);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      2'b00: begin p = 64'(sa * sb); return p; end
      2'b01: begin p = ua * ub; return p; end
      2'b10: begin
        if (b == 32'd0) return {hi, lo};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {hi, lo};
        return {32'(ua % ub), 32'(ua / ub)};
      end
    endcase
  endfunction

  // Model state: cycles of busy remaining, pending result, architectural HI/LO.
  int          m_left;
  logic [63:0] m_pend;
  logic [31:0] m_hi, m_lo;
  logic        m_done;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_left <= 0;
      m_pend <= '0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_left == 0) begin
        if (bus.start) begin
          m_pend <= ref_md(bus.md_op, bus.src_a, bus.src_b, m_hi, m_lo);
          m_left <= bus.md_op[1] ? DIV_LAT : MUL_LAT;
        end else begin
          if (bus.wr_hi) m_hi <= bus.wr_data;
          if (bus.wr_lo) m_lo <= bus.wr_data;
        end
      end else begin
        if (bus.start) chk("start_while_busy", 32'd1, 32'd0);
        if (m_left == 1) begin
          m_hi   <= m_pend[63:32];
          m_lo   <= m_pend[31:0];
          m_done <= 1'b1;
        end
        m_left <= m_left - 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy",  bus.busy,  (m_left != 0) ? 32'd1 : 32'd0);
    chk("done",  bus.done,  m_done);
    chk("hi",    bus.hi,    m_hi);
    chk("lo",    bus.lo,    m_lo);
    chk("stall", bus.stall, (bus.id_md_use && ((m_left != 0) || bus.start)) ? 32'd1 : 32'd0);
    if (bus.busy)  busy_cnt++;
    if (bus.done)  done_cnt++;
    if (bus.stall) stall_cnt++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic clr_cnt();
    busy_cnt = 0;
    done_cnt = 0;
    stall_cnt = 0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.md_op = op;
    bus.src_a = a;
    bus.src_b = b;
    cyc();
    bus.start = 1'b0;
  endtask

  task automatic write_hilo(input logic hi_sel, input logic [31:0] d);
    bus.wr_hi   = hi_sel;
    bus.wr_lo   = ~hi_sel;
    bus.wr_data = d;
    cyc();
    bus.wr_hi = 1'b0;
    bus.wr_lo = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0; bus.md_op = 2'b00; bus.src_a = '0; bus.src_b = '0;
    bus.wr_hi = 1'b0; bus.wr_lo = 1'b0; bus.wr_data = '0; bus.id_md_use = 1'b0;

    run(2);
    chk("rst_busy", bus.busy, 32'd0);
    chk("rst_hi",   bus.hi,   32'd0);
    chk("rst_lo",   bus.lo,   32'd0);
    rst = 1'b1;
    cyc();

    // 1: signed mult
    clr_cnt();
    issue(2'b00, 32'hFFFF_FFFE, 32'd3);
    run(MUL_LAT + 2);
    chk("t1_hi", bus.hi, 32'hFFFF_FFFF);
    chk("t1_lo", bus.lo, 32'hFFFF_FFFA);
    chk("t1_busy_cycles", busy_cnt, MUL_LAT);
    chk("t1_done_pulses", done_cnt, 32'd1);
    $display("txn mult  a=fffffffe b=00000003 -> hi=%08h lo=%08h", bus.hi, bus.lo);

    // 2: multu with an mflo waiting in ID during the window
    clr_cnt();
    issue(2'b01, 32'hFFFF_FFFF, 32'd2);
    bus.id_md_use = 1'b1;
    run(MUL_LAT + 1);
    bus.id_md_use = 1'b0;
    cyc();
    chk("t2_hi", bus.hi, 32'h0000_0001);
    chk("t2_lo", bus.lo, 32'hFFFF_FFFE);
    chk("t2_stall_cycles", stall_cnt, MUL_LAT);
    $display("txn multu a=ffffffff b=00000002 -> hi=%08h lo=%08h", bus.hi, bus.lo);

    // 3: signed divide, then the overflow case
    clr_cnt();
    issue(2'b10, 32'hFFFF_FFF9, 32'd2);
    run(DIV_LAT + 2);
    chk("t3_hi", bus.hi, 32'hFFFF_FFFF);
    chk("t3_lo", bus.lo, 32'hFFFF_FFFD);
    chk("t3_busy_cycles", busy_cnt, DIV_LAT);
    $display("txn div   a=fffffff9 b=00000002 -> hi=%08h lo=%08h", bus.hi, bus.lo);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run(DIV_LAT + 2);
    chk("t3_ovf_hi", bus.hi, 32'h0000_0000);
    chk("t3_ovf_lo", bus.lo, 32'h8000_0000);
    $display("txn div   a=80000000 b=ffffffff -> hi=%08h lo=%08h", bus.hi, bus.lo);

    // 4: divu by zero leaves HI/LO as written by mthi/mtlo
    write_hilo(1'b1, 32'h0000_1234);
    write_hilo(1'b0, 32'h0000_5678);
    clr_cnt();
    issue(2'b11, 32'd99, 32'd0);
    run(DIV_LAT + 2);
    chk("t4_hi", bus.hi, 32'h0000_1234);
    chk("t4_lo", bus.lo, 32'h0000_5678);
    chk("t4_busy_cycles", busy_cnt, DIV_LAT);
    $display("txn divu  a=00000063 b=00000000 -> hi=%08h lo=%08h", bus.hi, bus.lo);

    // 5: asynchronous reset in the third busy cycle of a divide
    issue(2'b10, 32'd100, 32'd7);
    run(2);
    #2;
    rst = 1'b0;
    #1;
    chk("t5_busy_async", bus.busy, 32'd0);
    chk("t5_hi_async",   bus.hi,   32'd0);
    chk("t5_lo_async",   bus.lo,   32'd0);
    run(2);
    rst = 1'b1;
    clr_cnt();
    run(DIV_LAT + 4);
    chk("t5_no_done", done_cnt, 32'd0);
    chk("t5_no_busy", busy_cnt, 32'd0);
    $display("txn reset mid-div -> busy=%0d hi=%08h lo=%08h", bus.busy, bus.hi, bus.lo);

    // 6: start and mtlo together; start wins
    bus.id_md_use = 1'b1;
    #1;
    chk("t6_idle_stall", bus.stall, 32'd0);
    bus.start = 1'b1; bus.md_op = 2'b00; bus.src_a = 32'd6; bus.src_b = 32'd7;
    bus.wr_lo = 1'b1; bus.wr_data = 32'hDEAD_BEEF;
    #1;
    chk("t6_start_stall", bus.stall, 32'd1);
    cyc();
    bus.start = 1'b0; bus.wr_lo = 1'b0; bus.id_md_use = 1'b0;
    run(MUL_LAT + 2);
    chk("t6_lo", bus.lo, 32'd42);
    chk("t6_hi", bus.hi, 32'd0);
    $display("txn mult  a=00000006 b=00000007 +mtlo -> hi=%08h lo=%08h", bus.hi, bus.lo);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
